// File: rtl/matmul_stream_sequencer.sv
// matmul_stream_sequencer
//   Job controller for the matrix-multiplier AXI-stream input port. A start
//   pulse launches a job: a ready-qualified warm-up, then a matrix packet
//   (header + mat_len words) and a vector packet (header + vec_len words),
//   payload taken from the upstream source stream. The job stays busy until
//   the accelerator result stream delivers its TLAST, then pulses done.
//
// Ports
//   clk, reset                 clock (rising edge), async active-high reset
//   start, mat_len, vec_len    job request and per-packet payload word counts
//   busy, done, err_last       job status; err_last is sticky until next start
//   s_axis_*                   payload source stream (TLAST checked only)
//   input_r_*_0                packet stream towards the accelerator
//   output_r_*_0               accelerator result stream, monitored only
module matmul_stream_sequencer #(
  parameter int          DATA_W      = 32,
  parameter int          LEN_W       = 14,
  parameter logic [7:0]  HDR_TAG     = 8'hFF,
  parameter int          START_DELAY = 20000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  mat_len,
  input  logic [LEN_W-1:0]  vec_len,
  output logic              busy,
  output logic              done,
  output logic              err_last,
  input  logic [DATA_W-1:0] s_axis_TDATA,
  input  logic              s_axis_TVALID,
  input  logic              s_axis_TLAST,
  output logic              s_axis_TREADY,
  output logic [DATA_W-1:0] input_r_TDATA_0,
  output logic              input_r_TVALID_0,
  output logic              input_r_TLAST_0,
  input  logic              input_r_TREADY_0,
  input  logic              output_r_TVALID_0,
  input  logic              output_r_TREADY_0,
  input  logic              output_r_TLAST_0
);

  localparam int WARM_W = (START_DELAY > 1) ? $clog2(START_DELAY + 1) : 1;
  localparam logic [WARM_W-1:0] DELAY_C = WARM_W'(START_DELAY);

  typedef enum logic [2:0] {
    IDLE, WARM, HDR_A, PAY_A, HDR_B, PAY_B, WAIT_RES
  } state_t;

  state_t              state_q, state_d;
  logic [WARM_W-1:0]   warm_cnt;
  logic [LEN_W-1:0]    word_cnt;
  logic [LEN_W-1:0]    mat_len_q, vec_len_q;
  logic                busy_q, done_q, err_q;

  // Output register stage
  logic                vld_p0, last_p0;
  logic [DATA_W-1:0]   data_p0;

  logic                load_en, cnt_last;
  logic [LEN_W-1:0]    cur_len;
  logic                ld, ld_last, src_rdy, beat, start_acc, done_d;
  logic [DATA_W-1:0]   ld_data;

  // Header carries the payload byte count in its low 16 bits.
  function automatic logic [DATA_W-1:0] make_hdr(input logic [LEN_W-1:0] len);
    logic [15:0] byte_cnt;
    byte_cnt = 16'(len) << 2;
    return DATA_W'({HDR_TAG, 8'h00, byte_cnt});
  endfunction

  // The output register can take a new word whenever it is empty or draining.
  assign load_en  = !vld_p0 || input_r_TREADY_0;
  assign cur_len  = (state_q == PAY_A) ? mat_len_q : vec_len_q;
  assign cnt_last = (word_cnt == cur_len - LEN_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    ld        = 1'b0;
    ld_data   = '0;
    ld_last   = 1'b0;
    src_rdy   = 1'b0;
    beat      = 1'b0;
    start_acc = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          state_d   = WARM;
        end
      end
      WARM: begin
        // Leave on the cycle whose ready beat brings the count to the target,
        // so the warm-up lasts exactly START_DELAY ready-high cycles.
        if (warm_cnt == DELAY_C ||
            (input_r_TREADY_0 && (warm_cnt + WARM_W'(1)) == DELAY_C))
          state_d = HDR_A;
      end
      HDR_A, HDR_B: begin
        if (load_en) begin
          ld      = 1'b1;
          ld_data = make_hdr((state_q == HDR_A) ? mat_len_q : vec_len_q);
          ld_last = ((state_q == HDR_A) ? mat_len_q : vec_len_q) == '0;
          if (state_q == HDR_A) state_d = ld_last ? HDR_B : PAY_A;
          else                  state_d = ld_last ? WAIT_RES : PAY_B;
        end
      end
      PAY_A, PAY_B: begin
        src_rdy = load_en;
        if (load_en && s_axis_TVALID) begin
          ld      = 1'b1;
          beat    = 1'b1;
          ld_data = s_axis_TDATA;
          ld_last = cnt_last;
          if (cnt_last) state_d = (state_q == PAY_A) ? HDR_B : WAIT_RES;
        end
      end
      WAIT_RES: begin
        // Results only count once the final input beat has left the register.
        if (!vld_p0 && output_r_TVALID_0 && output_r_TREADY_0 && output_r_TLAST_0) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      warm_cnt  <= '0;
      word_cnt  <= '0;
      mat_len_q <= '0;
      vec_len_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      vld_p0    <= 1'b0;
      last_p0   <= 1'b0;
      data_p0   <= '0;
    end else begin
      done_q <= done_d;
      if (start_acc) begin
        busy_q    <= 1'b1;
        err_q     <= 1'b0;
        mat_len_q <= mat_len;
        vec_len_q <= vec_len;
        warm_cnt  <= '0;
        word_cnt  <= '0;
      end
      if (done_d) busy_q <= 1'b0;
      if (state_q == WARM && input_r_TREADY_0) warm_cnt <= warm_cnt + WARM_W'(1);
      if (beat) begin
        word_cnt <= cnt_last ? '0 : word_cnt + LEN_W'(1);
        if (s_axis_TLAST != cnt_last) err_q <= 1'b1;
      end
      if (load_en) vld_p0 <= ld;
      if (ld) begin
        data_p0 <= ld_data;
        last_p0 <= ld_last;
      end
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign err_last         = err_q;
  assign s_axis_TREADY    = src_rdy;
  assign input_r_TDATA_0  = data_p0;
  assign input_r_TVALID_0 = vld_p0;
  assign input_r_TLAST_0  = last_p0;

endmodule

// File: tb/tb_matmul_stream_sequencer.sv
module tb_matmul_stream_sequencer;

  localparam int DATA_W = 32;
  localparam int LEN_W  = 14;
  localparam int SD     = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [LEN_W-1:0]  mat_len = '0;
  logic [LEN_W-1:0]  vec_len = '0;
  logic              busy, done, err_last;
  logic [DATA_W-1:0] s_axis_TDATA = '0;
  logic              s_axis_TVALID = 1'b0;
  logic              s_axis_TLAST = 1'b0;
  logic              s_axis_TREADY;
  logic [DATA_W-1:0] input_r_TDATA_0;
  logic              input_r_TVALID_0, input_r_TLAST_0;
  logic              input_r_TREADY_0 = 1'b0;
  logic              output_r_TVALID_0 = 1'b0;
  logic              output_r_TREADY_0 = 1'b0;
  logic              output_r_TLAST_0 = 1'b0;

  matmul_stream_sequencer #(
    .DATA_W(DATA_W), .LEN_W(LEN_W), .HDR_TAG(8'hFF), .START_DELAY(SD)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .mat_len(mat_len), .vec_len(vec_len),
    .busy(busy), .done(done), .err_last(err_last),
    .s_axis_TDATA(s_axis_TDATA), .s_axis_TVALID(s_axis_TVALID),
    .s_axis_TLAST(s_axis_TLAST), .s_axis_TREADY(s_axis_TREADY),
    .input_r_TDATA_0(input_r_TDATA_0), .input_r_TVALID_0(input_r_TVALID_0),
    .input_r_TLAST_0(input_r_TLAST_0), .input_r_TREADY_0(input_r_TREADY_0),
    .output_r_TVALID_0(output_r_TVALID_0), .output_r_TREADY_0(output_r_TREADY_0),
    .output_r_TLAST_0(output_r_TLAST_0)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] got_data[$];
  logic        got_last[$];
  int          first_vld, stab_err, done_seen, bad;
  bit          timed_out;

  // Expected beat i of a job: {last, data}. Source word n is 32'hC0DE0000+n.
  function automatic logic [32:0] exp_beat(input int i, input int mat, input int vec);
    logic [31:0] d;
    logic        l;
    if (i == 0) begin
      d = {8'hFF, 8'h00, 16'(mat * 4)}; l = (mat == 0);
    end else if (i <= mat) begin
      d = 32'hC0DE0000 + 32'(i - 1); l = (i == mat);
    end else if (i == mat + 1) begin
      d = {8'hFF, 8'h00, 16'(vec * 4)}; l = (vec == 0);
    end else begin
      d = 32'hC0DE0000 + 32'(i - 2); l = (i == mat + vec + 1);
    end
    return {l, d};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts a job and runs both streams until all packet beats are collected.
  // rdy_mode: 0 always ready, 1 toggling from the first WARM cycle, 2 random.
  task automatic drive_job(input int mat, input int vec, input int rdy_mode,
                           input int vld_mode, input bit bad_last,
                           input bit res_hold, input int budget);
    int          idx, k;
    bit          hs_src, stall;
    logic [31:0] sd;
    logic        sl;
    got_data.delete();
    got_last.delete();
    first_vld = -1; stab_err = 0; done_seen = 0; timed_out = 0;
    idx = 0; stall = 0; sd = '0; sl = 1'b0; k = 0;
    mat_len = LEN_W'(mat);
    vec_len = LEN_W'(vec);
    start = 1'b1;
    step();
    start = 1'b0;
    while (got_data.size() < mat + vec + 2) begin
      if (k >= budget) begin
        timed_out = 1;
        break;
      end
      if (stall && (!input_r_TVALID_0 || input_r_TDATA_0 !== sd || input_r_TLAST_0 !== sl))
        stab_err++;
      if (first_vld < 0 && input_r_TVALID_0) first_vld = k;
      if (done) done_seen++;
      case (rdy_mode)
        0:       input_r_TREADY_0 = 1'b1;
        1:       input_r_TREADY_0 = (k % 2 == 0);
        default: input_r_TREADY_0 = ($urandom_range(0, 3) != 0);
      endcase
      s_axis_TVALID = (vld_mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
      s_axis_TDATA  = 32'hC0DE0000 + 32'(idx);
      s_axis_TLAST  = bad_last ? (idx == 1) : (idx == mat - 1 || idx == mat + vec - 1);
      output_r_TVALID_0 = res_hold;
      output_r_TREADY_0 = res_hold;
      output_r_TLAST_0  = res_hold;
      #1;
      if (input_r_TVALID_0 && input_r_TREADY_0) begin
        got_data.push_back(input_r_TDATA_0);
        got_last.push_back(input_r_TLAST_0);
      end
      hs_src = s_axis_TVALID && s_axis_TREADY;
      stall  = input_r_TVALID_0 && !input_r_TREADY_0;
      sd     = input_r_TDATA_0;
      sl     = input_r_TLAST_0;
      step();
      if (hs_src) idx++;
      k++;
    end
    output_r_TVALID_0 = 1'b0;
    output_r_TREADY_0 = 1'b0;
    output_r_TLAST_0  = 1'b0;
    s_axis_TVALID     = 1'b0;
    s_axis_TLAST      = 1'b0;
    input_r_TREADY_0  = 1'b1;
  endtask

  task automatic pulse_result();
    output_r_TVALID_0 = 1'b1;
    output_r_TREADY_0 = 1'b1;
    output_r_TLAST_0  = 1'b1;
    step();
    output_r_TVALID_0 = 1'b0;
    output_r_TREADY_0 = 1'b0;
    output_r_TLAST_0  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (err_last !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err_last); end
    n_cmp++; if (s_axis_TREADY !== 1'b0) begin n_bad++; $display("FAIL reset_sready: got %b want 0", s_axis_TREADY); end
    n_cmp++; if (input_r_TVALID_0 !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", input_r_TVALID_0); end
    n_cmp++; if (input_r_TDATA_0 !== 32'h0) begin n_bad++; $display("FAIL reset_data: got %h want 0", input_r_TDATA_0); end
    n_cmp++; if (input_r_TLAST_0 !== 1'b0) begin n_bad++; $display("FAIL reset_last: got %b want 0", input_r_TLAST_0); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_long_job();
    drive_job(1764, 126, 0, 0, 1'b0, 1'b0, 6000);
    n_cmp++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL long_timeout: got %0d beats want 1892", got_data.size()); end
    n_cmp++; if (got_data.size() !== 1892) begin n_bad++; $display("FAIL long_count: got %0d want 1892", got_data.size()); end
    n_cmp++; if (first_vld !== 5) begin n_bad++; $display("FAIL long_warm: first valid at %0d want 5", first_vld); end
    n_cmp++; if (got_data[0] !== 32'hFF001B90) begin n_bad++; $display("FAIL long_hdr_a: got %h want FF001B90", got_data[0]); end
    n_cmp++; if (got_data[1765] !== 32'hFF0001F8) begin n_bad++; $display("FAIL long_hdr_b: got %h want FF0001F8", got_data[1765]); end
    n_cmp++; if (got_last[1764] !== 1'b1) begin n_bad++; $display("FAIL long_last_a: got %b want 1", got_last[1764]); end
    n_cmp++; if (got_last[1891] !== 1'b1) begin n_bad++; $display("FAIL long_last_b: got %b want 1", got_last[1891]); end
    bad = 0;
    for (int i = 0; i < got_data.size(); i++)
      if ({got_last[i], got_data[i]} !== exp_beat(i, 1764, 126)) bad++;
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL long_stream: %0d beats differ, want 0", bad); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL long_busy_wait: got %b want 1", busy); end
    pulse_result();
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL long_done: got %b want 1", done); end
    step();
  endtask

  task automatic test_warm_toggle();
    drive_job(2, 1, 1, 0, 1'b0, 1'b0, 200);
    n_cmp++; if (first_vld !== 8) begin n_bad++; $display("FAIL toggle_warm: first valid at %0d want 8", first_vld); end
    n_cmp++; if (got_data.size() !== 5) begin n_bad++; $display("FAIL toggle_count: got %0d want 5", got_data.size()); end
    bad = 0;
    for (int i = 0; i < got_data.size(); i++)
      if ({got_last[i], got_data[i]} !== exp_beat(i, 2, 1)) bad++;
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL toggle_stream: %0d beats differ, want 0", bad); end
    pulse_result();
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL toggle_done: got %b want 1", done); end
    step();
  endtask

  task automatic test_stalls();
    drive_job(3, 2, 2, 1, 1'b0, 1'b1, 400);
    n_cmp++; if (got_data.size() !== 7) begin n_bad++; $display("FAIL stall_count: got %0d want 7", got_data.size()); end
    bad = 0;
    for (int i = 0; i < got_data.size(); i++)
      if ({got_last[i], got_data[i]} !== exp_beat(i, 3, 2)) bad++;
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL stall_stream: %0d beats differ, want 0", bad); end
    n_cmp++; if (stab_err !== 0) begin n_bad++; $display("FAIL stall_hold: %0d unstable stalls, want 0", stab_err); end
    n_cmp++; if (done_seen !== 0) begin n_bad++; $display("FAIL stall_early_done: got %0d want 0", done_seen); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL stall_same_cycle_res: done %b want 0", done); end
    n_cmp++; if (err_last !== 1'b0) begin n_bad++; $display("FAIL stall_err: got %b want 0", err_last); end
    pulse_result();
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL stall_done: got %b want 1", done); end
    step();
  endtask

  task automatic test_empty_vec();
    drive_job(2, 0, 0, 0, 1'b0, 1'b0, 200);
    n_cmp++; if (got_data.size() !== 4) begin n_bad++; $display("FAIL empty_count: got %0d want 4", got_data.size()); end
    n_cmp++; if (got_data[3] !== 32'hFF000000) begin n_bad++; $display("FAIL empty_hdr: got %h want FF000000", got_data[3]); end
    n_cmp++; if (got_last[3] !== 1'b1) begin n_bad++; $display("FAIL empty_last: got %b want 1", got_last[3]); end
    bad = 0;
    for (int i = 0; i < got_data.size(); i++)
      if ({got_last[i], got_data[i]} !== exp_beat(i, 2, 0)) bad++;
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL empty_stream: %0d beats differ, want 0", bad); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL empty_busy: got %b want 1", busy); end
    pulse_result();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL empty_busy_end: got %b want 0", busy); end
    step();
  endtask

  task automatic test_err_last();
    drive_job(3, 1, 0, 0, 1'b1, 1'b0, 200);
    n_cmp++; if (err_last !== 1'b1) begin n_bad++; $display("FAIL err_flag: got %b want 1", err_last); end
    n_cmp++; if (got_last[2] !== 1'b0) begin n_bad++; $display("FAIL err_no_early_last: got %b want 0", got_last[2]); end
    n_cmp++; if (got_last[3] !== 1'b1) begin n_bad++; $display("FAIL err_count_last: got %b want 1", got_last[3]); end
    bad = 0;
    for (int i = 0; i < got_data.size(); i++)
      if ({got_last[i], got_data[i]} !== exp_beat(i, 3, 1)) bad++;
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL err_stream: %0d beats differ, want 0", bad); end
    pulse_result();
    n_cmp++; if (err_last !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got %b want 1", err_last); end
    step();
  endtask

  task automatic test_done_and_restart();
    int vld_cnt, busy_cnt;
    drive_job(2, 1, 0, 0, 1'b0, 1'b0, 200);
    n_cmp++; if (err_last !== 1'b0) begin n_bad++; $display("FAIL restart_err_clear: got %b want 0", err_last); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL restart_done_early: got %b want 0", done); end
    mat_len = LEN_W'(5);
    start = 1'b1;
    step();
    start = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL restart_busy: got %b want 1", busy); end
    pulse_result();
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL restart_done: got %b want 1", done); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL restart_busy_drop: got %b want 0", busy); end
    step();
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL restart_done_pulse: got %b want 0", done); end
    vld_cnt = 0; busy_cnt = 0;
    input_r_TREADY_0 = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (input_r_TVALID_0) vld_cnt++;
      if (busy) busy_cnt++;
      step();
    end
    n_cmp++; if (vld_cnt !== 0) begin n_bad++; $display("FAIL restart_no_job: %0d valid cycles want 0", vld_cnt); end
    n_cmp++; if (busy_cnt !== 0) begin n_bad++; $display("FAIL restart_idle: %0d busy cycles want 0", busy_cnt); end
  endtask

  task automatic test_reset_mid_packet();
    mat_len = LEN_W'(50);
    vec_len = LEN_W'(1);
    input_r_TREADY_0 = 1'b1;
    s_axis_TVALID = 1'b1;
    s_axis_TDATA = 32'hC0DE0000;
    s_axis_TLAST = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 10; k++) step();
    n_cmp++; if (input_r_TVALID_0 !== 1'b1) begin n_bad++; $display("FAIL midrst_pre_valid: got %b want 1", input_r_TVALID_0); end
    #3;
    reset = 1'b1;
    #1;
    n_cmp++; if (input_r_TVALID_0 !== 1'b0) begin n_bad++; $display("FAIL midrst_valid: got %b want 0", input_r_TVALID_0); end
    n_cmp++; if (input_r_TDATA_0 !== 32'h0) begin n_bad++; $display("FAIL midrst_data: got %h want 0", input_r_TDATA_0); end
    n_cmp++; if (s_axis_TREADY !== 1'b0) begin n_bad++; $display("FAIL midrst_sready: got %b want 0", s_axis_TREADY); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
    s_axis_TVALID = 1'b0;
    step();
    reset = 1'b0;
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_long_job();
    test_warm_toggle();
    test_stalls();
    test_empty_vec();
    test_err_last();
    test_done_and_restart();
    test_reset_mid_packet();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
